// File: rtl/ndp_drain_pkg.sv
// Shared types and size helpers for the NDP result drain.
// The top module derives its vector sizes from these functions.
package ndp_drain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } drain_state_e;

  function automatic int calc_result_bits(input int arr_w, input int arr_h,
                                          input int sys_w, input int sys_h,
                                          input int width);
    return arr_w * sys_w * arr_h * sys_h * width;
  endfunction

  function automatic int calc_num_words(input int result_bits, input int word_width);
    return result_bits / word_width;
  endfunction

  function automatic int calc_idx_bits(input int num_words);
    return (num_words > 32'sd1) ? $clog2(num_words) : 32'sd1;
  endfunction

  function automatic bit word_width_ok(input int word_width, input int width);
    return (width > 32'sd0) && ((word_width % width) == 32'sd0);
  endfunction

endpackage

// File: rtl/ndp_result_drain_postop.sv
// Per-element FP16 ReLU over one output word.
// With RELU_EN=0 the word passes through bit-exact.
module ndp_word_postop #(
  parameter int WIDTH      = 16,
  parameter int WORD_WIDTH = 32,
  parameter int RELU_EN    = 0
) (
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic [WORD_WIDTH-1:0] word_out
);

  localparam int ELEMS = WORD_WIDTH / WIDTH;

  // Zero each element whose sign bit is set, -0 and negative NaN included
  always_comb begin
    word_out = word_in;
    for (int e = 0; e < ELEMS; e++) begin
      if ((RELU_EN != 0) && word_in[WIDTH*e + WIDTH - 1]) begin
        word_out[WIDTH*e +: WIDTH] = '0;
      end else begin
        word_out[WIDTH*e +: WIDTH] = word_in[WIDTH*e +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/ndp_result_drain.sv
// Captures the NDP core result vector on a rising calc_done_flag and streams
// it out word by word over valid/ready, freeing the core right after capture.
module ndp_result_drain
  import ndp_drain_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ARR_WIDTH  = 4,
  parameter int ARR_HEIGHT = 4,
  parameter int SYS_WIDTH  = 64,
  parameter int SYS_HEIGHT = 1,
  parameter int WORD_WIDTH = 32,
  parameter int RELU_EN    = 0,
  localparam int RESULT_BITS = calc_result_bits(ARR_WIDTH, ARR_HEIGHT, SYS_WIDTH,
                                                SYS_HEIGHT, WIDTH),
  localparam int NUM_WORDS   = calc_num_words(RESULT_BITS, WORD_WIDTH),
  localparam int IDX_BITS    = calc_idx_bits(NUM_WORDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   calc_done_flag,
  input  logic [RESULT_BITS-1:0] in_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   drain_done,
  output logic                   overrun
);

  if (!word_width_ok(WORD_WIDTH, WIDTH)) begin : g_word_width_check
    $error("ndp_result_drain: WORD_WIDTH must be a multiple of WIDTH");
  end

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_WORDS - 1);

  drain_state_e           state_r, state_nxt_s;
  logic [IDX_BITS-1:0]    word_idx_r, word_idx_nxt_s;
  logic                   done_q_r;
  logic                   overrun_r, overrun_nxt_s;
  logic                   trigger_s, capture_s, last_word_s;
  logic [RESULT_BITS-1:0] result_reg_r;
  logic [WORD_WIDTH-1:0]  raw_word_s;

  // done_q_r resets high so a flag already raised at reset release is not an edge
  assign trigger_s   = calc_done_flag & ~done_q_r;
  assign last_word_s = (word_idx_r == LAST_IDX);

  // Next-state, word counter and overrun logic
  always_comb begin
    state_nxt_s    = state_r;
    word_idx_nxt_s = word_idx_r;
    overrun_nxt_s  = overrun_r;
    capture_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (trigger_s) begin
          capture_s      = 1'b1;
          word_idx_nxt_s = '0;
          state_nxt_s    = STREAM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STREAM: begin
        if (trigger_s) begin
          overrun_nxt_s = 1'b1;
        end else begin
          overrun_nxt_s = overrun_r;
        end
        if (out_ready) begin
          if (last_word_s) begin
            state_nxt_s = DONE;
          end else begin
            word_idx_nxt_s = word_idx_r + IDX_BITS'(1);
          end
        end else begin
          state_nxt_s = STREAM;
        end
      end
      DONE: begin
        if (trigger_s) begin
          overrun_nxt_s = 1'b1;
        end else begin
          overrun_nxt_s = overrun_r;
        end
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      word_idx_r <= '0;
      done_q_r   <= 1'b1;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      word_idx_r <= word_idx_nxt_s;
      done_q_r   <= calc_done_flag;
      overrun_r  <= overrun_nxt_s;
    end
  end

  // Result capture; contents are don't-care until the first trigger
  always_ff @(posedge clk) begin
    if (capture_s) begin
      result_reg_r <= in_c;
    end
  end

  assign raw_word_s = result_reg_r[word_idx_r*WORD_WIDTH +: WORD_WIDTH];

  ndp_word_postop #(
    .WIDTH      (WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .RELU_EN    (RELU_EN)
  ) u_postop (
    .word_in  (raw_word_s),
    .word_out (out_data)
  );

  assign out_valid  = (state_r == STREAM);
  assign out_last   = (state_r == STREAM) & last_word_s;
  assign busy       = (state_r != IDLE);
  assign drain_done = (state_r == DONE);
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_ndp_result_drain.sv
// Directed scoreboard bench for ndp_result_drain; a plain and a ReLU instance
// share all inputs and are checked word by word against bench-computed queues.
module tb_ndp_result_drain;

  localparam int WW = 32;
  localparam int RB = 16384;
  localparam int NW = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          calc_done_flag;
  logic          out_ready;
  logic [RB-1:0] in_c;

  logic          ov0, ol0, b0, dd0, or0;
  logic [WW-1:0] od0;
  logic          ov1, ol1, b1, dd1, or1;
  logic [WW-1:0] od1;

  ndp_result_drain #(.RELU_EN(0)) dut0 (
    .clk(clk), .reset(reset), .calc_done_flag(calc_done_flag), .in_c(in_c),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0),
    .busy(b0), .drain_done(dd0), .overrun(or0)
  );

  ndp_result_drain #(.RELU_EN(1)) dut1 (
    .clk(clk), .reset(reset), .calc_done_flag(calc_done_flag), .in_c(in_c),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1),
    .busy(b1), .drain_done(dd1), .overrun(or1)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          xfer0 = 0;
  int          dd0_cnt = 0;
  int          dd_base, xfer_base;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        stall_p[2];
  logic [31:0] data_p[2];
  logic        last_p[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mon_port(input int id, input logic v, input logic [31:0] d, input logic l);
    logic [31:0] exp;
    int          left;
    bit          have;
    if (stall_p[id]) begin
      chk("hold_valid", v, 1);
      chk("hold_data", d, data_p[id]);
      chk("hold_last", l, last_p[id]);
    end
    if (!v) chk("last_while_idle", l, 0);
    if (v && out_ready) begin
      have = (id == 0) ? (q0.size() != 0) : (q1.size() != 0);
      chk("word_expected", have, 1);
      if (have) begin
        if (id == 0) begin
          exp = q0.pop_front(); left = q0.size(); xfer0++;
        end else begin
          exp = q1.pop_front(); left = q1.size();
        end
        chk((id == 0) ? "data_plain" : "data_relu", d, exp);
        chk("out_last", l, (left == 0));
      end
    end
    stall_p[id] = v && !out_ready && !reset;
    data_p[id]  = d;
    last_p[id]  = l;
  endtask

  // One clock: monitor at the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    mon_port(0, ov0, od0, ol0);
    mon_port(1, ov1, od1, ol1);
    if (dd0) dd0_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    logic [31:0] w, r;
    for (int k = 0; k < NW; k++) begin
      w = in_c[WW*k +: WW];
      r = w;
      for (int e = 0; e < 2; e++) begin
        if (w[16*e + 15]) r[16*e +: 16] = 16'h0000;
      end
      q0.push_back(w);
      q1.push_back(r);
    end
  endtask

  task automatic fill_ramp();
    for (int e = 0; e < RB/16; e++) in_c[16*e +: 16] = 16'(e);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < NW; k++) in_c[WW*k +: WW] = $urandom;
  endtask

  task automatic fill_alt();
    for (int e = 0; e < RB/16; e++) in_c[16*e +: 16] = (e % 2 == 0) ? 16'hBC00 : 16'h3C00;
  endtask

  // Raise the flag with expected words queued; first word is valid one edge later
  task automatic start_drain();
    push_expected();
    dd_base   = dd0_cnt;
    xfer_base = xfer0;
    calc_done_flag = 1'b1;
    chk("valid_before_edge", ov0, 0);
    tick();
    chk("first_valid", ov0, 1);
    chk("busy_stream", b0, 1);
  endtask

  // mode 0: ready high, 1: ready one cycle in three, 2: random ready
  task automatic run_to_idle(input int mode, input bit scramble, input int budget);
    int n;
    for (n = 0; n < budget && b0; n++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (scramble) fill_rand();
      tick();
    end
    chk("drain_in_budget", b0, 0);
    chk("queue0_empty", q0.size(), 0);
    chk("queue1_empty", q1.size(), 0);
    chk("word_count", xfer0 - xfer_base, NW);
    chk("drain_done_count", dd0_cnt - dd_base, 1);
  endtask

  initial begin
    reset = 1'b1; calc_done_flag = 1'b0; out_ready = 1'b0; in_c = '0;
    for (int i = 0; i < 2; i++) begin stall_p[i] = 1'b0; data_p[i] = '0; last_p[i] = 1'b0; end
    repeat (3) tick();
    chk("rst_valid", ov0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_drain_done", dd0, 0);
    chk("rst_overrun", or0, 0);
    chk("rst_last", ol0, 0);
    reset = 1'b0;
    repeat (2) tick();

    // Basic drain, flag held high for the whole drain
    fill_ramp();
    out_ready = 1'b1;
    start_drain();
    chk("first_word", od0, 32'h00010000);
    tick();
    chk("second_word", od0, 32'h00030002);
    repeat (510) tick();
    chk("last_word", od0, 32'h03FF03FE);
    chk("last_flag", ol0, 1);
    tick();
    chk("done_pulse", dd0, 1);
    chk("done_valid", ov0, 0);
    chk("done_busy", b0, 1);
    tick();
    chk("idle_busy", b0, 0);
    chk("idle_done", dd0, 0);
    chk("basic_count", xfer0 - xfer_base, NW);
    chk("basic_queue", q0.size(), 0);
    repeat (5) tick();
    chk("level_no_redrain", ov0, 0);
    chk("level_overrun", or0, 0);
    calc_done_flag = 1'b0;
    tick();

    // Backpressure with random data
    fill_rand();
    out_ready = 1'b0;
    start_drain();
    run_to_idle(1, 1'b0, 3000);
    calc_done_flag = 1'b0;
    tick();

    // ReLU: -1.0 / +1.0 alternating elements
    fill_alt();
    out_ready = 1'b1;
    start_drain();
    chk("plain_word", od0, 32'h3C00BC00);
    chk("relu_word", od1, 32'h3C000000);
    run_to_idle(0, 1'b0, 1000);
    calc_done_flag = 1'b0;
    tick();

    // Second rising edge at word 100
    fill_ramp();
    out_ready = 1'b1;
    start_drain();
    repeat (100) tick();
    calc_done_flag = 1'b0;
    tick();
    calc_done_flag = 1'b1;
    tick();
    chk("overrun_set", or0, 1);
    run_to_idle(0, 1'b0, 1000);
    chk("overrun_sticky", or0, 1);
    repeat (3) tick();
    chk("overrun_no_redrain", ov0, 0);
    calc_done_flag = 1'b0;
    tick();

    // Reset at word 200 with the flag high through reset release
    fill_rand();
    out_ready = 1'b1;
    start_drain();
    repeat (200) tick();
    out_ready = 1'b0;
    reset = 1'b1;
    dd_base = dd0_cnt;
    tick();
    chk("abort_valid", ov0, 0);
    chk("abort_busy", b0, 0);
    chk("abort_overrun", or0, 0);
    chk("abort_done", dd0, 0);
    q0.delete();
    q1.delete();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("held_flag_no_drain", ov0, 0);
    chk("abort_no_done", dd0_cnt - dd_base, 0);
    calc_done_flag = 1'b0;
    tick();
    fill_rand();
    out_ready = 1'b1;
    start_drain();
    chk("restart_word0", od0, in_c[31:0]);
    run_to_idle(0, 1'b0, 1000);

    // Trigger on the same edge as the last transfer
    calc_done_flag = 1'b0;
    tick();
    fill_rand();
    out_ready = 1'b1;
    start_drain();
    calc_done_flag = 1'b0;
    repeat (511) tick();
    calc_done_flag = 1'b1;
    tick();
    chk("last_trig_done", dd0, 1);
    chk("last_trig_overrun", or0, 1);
    chk("last_trig_valid", ov0, 0);
    tick();
    chk("last_trig_idle", b0, 0);
    repeat (3) tick();
    chk("last_trig_dropped", ov0, 0);
    chk("last_trig_queue", q0.size(), 0);

    // in_c scrambled every cycle after capture, random ready
    calc_done_flag = 1'b0;
    tick();
    fill_rand();
    start_drain();
    run_to_idle(2, 1'b1, 5000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
